intrusion_payload_gate: RTL and testbench

Downstream enforcement stage of the RDMA intrusion-detection path. It sits after `intrusion_detection_decider` and in parallel with `payload_extractor`. It buffers every raw 512-bit RX beat of an incoming RDMA packet until the decider's per-packet verdict arrives. On the verdict it forwards the whole packet unchanged toward the RDMA stack, or drops it and counts the drop. Packets and verdicts are in strict arrival order.

---
 rtl/ids_pkg.sv | 22 ++
 rtl/ids_beat_fifo.sv | 58 +++++
 rtl/intrusion_payload_gate.sv | 123 ++++++++++++
 tb/tb_intrusion_payload_gate.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ids_pkg.sv
`default_nettype none
// ============================================================================
// ids_pkg : shared types for the intrusion payload gate
// Rev 1.0
// ============================================================================
package ids_pkg;

   localparam int QPN_BITS = 24;

   typedef struct packed {
      logic                drop;
      logic [QPN_BITS-1:0] qpn;
   } ids_decision_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } ids_state_t;

endpackage
`default_nettype wire

// File: rtl/ids_beat_fifo.sv
`default_nettype none
// ============================================================================
// ids_beat_fifo : synchronous first-word-fall-through beat FIFO
// Rev 1.0
// ============================================================================
module ids_beat_fifo #(
   parameter int WIDTH = 577,
   parameter int DEPTH = 128,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   input  logic             i_rd_en,
   output logic [WIDTH-1:0] o_rd_data,
   output logic [AW:0]      o_count,
   output logic             o_full,
   output logic             o_empty
);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_wr;
   logic             w_do_rd;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];
   assign w_do_wr   = i_wr_en && !o_full;
   assign w_do_rd   = i_rd_en && !o_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_wr, w_do_rd})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage needs no reset: occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_data;
   end

endmodule
`default_nettype wire

// File: rtl/intrusion_payload_gate.sv
`default_nettype none
// ============================================================================
// intrusion_payload_gate : holds RX packets until their verdict, then forwards or drops them
// Rev 1.0
// ============================================================================
module intrusion_payload_gate
   import ids_pkg::*;
#(
   parameter int DEPTH_BEATS = 128,
   parameter int DATA_BITS   = 512
) (
   input  logic                   nclk,
   input  logic                   nreset,
   input  logic [DATA_BITS-1:0]   s_axis_rx_tdata,
   input  logic [DATA_BITS/8-1:0] s_axis_rx_tkeep,
   input  logic                   s_axis_rx_tlast,
   input  logic                   s_axis_rx_tvalid,
   output logic                   s_axis_rx_tready,
   input  logic [QPN_BITS:0]      s_decision_data,
   input  logic                   s_decision_valid,
   output logic                   s_decision_ready,
   output logic [DATA_BITS-1:0]   m_axis_tx_tdata,
   output logic [DATA_BITS/8-1:0] m_axis_tx_tkeep,
   output logic                   m_axis_tx_tlast,
   output logic                   m_axis_tx_tvalid,
   input  logic                   m_axis_tx_tready,
   output logic [31:0]            pass_cnt_o,
   output logic [31:0]            drop_cnt_o,
   output logic [QPN_BITS-1:0]    last_drop_qpn_o
);

   localparam int c_keep_bits = DATA_BITS / 8;
   localparam int c_fifo_bits = DATA_BITS + c_keep_bits + 1;
   localparam int c_occ_bits  = $clog2(DEPTH_BEATS) + 1;

   ids_state_t          r_state;
   logic [31:0]         r_pass_cnt;
   logic [31:0]         r_drop_cnt;
   logic [QPN_BITS-1:0] r_last_qpn;

   ids_decision_t         w_dec;
   logic [c_fifo_bits-1:0] w_head;
   logic [c_occ_bits-1:0]  w_occ;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_wr;
   logic                   w_rd;
   logic                   w_dec_accept;
   logic                   w_head_last;

   assign w_dec = s_decision_data;

   // Handshake outputs are forced low while reset is held.
   assign s_axis_rx_tready = !nreset && !w_full;
   assign s_decision_ready = !nreset && (r_state == ST_IDLE) && (w_occ != '0);
   assign m_axis_tx_tvalid = !nreset && (r_state == ST_PASS) && !w_empty;

   assign w_wr         = s_axis_rx_tvalid && s_axis_rx_tready;
   assign w_dec_accept = s_decision_valid && s_decision_ready;
   assign w_rd         = (m_axis_tx_tvalid && m_axis_tx_tready)
                       || (!nreset && (r_state == ST_DROP) && !w_empty);

   assign m_axis_tx_tdata = w_head[c_fifo_bits-1 -: DATA_BITS];
   assign m_axis_tx_tkeep = w_head[c_keep_bits:1];
   assign m_axis_tx_tlast = w_head[0];
   assign w_head_last     = w_head[0];

   assign pass_cnt_o      = r_pass_cnt;
   assign drop_cnt_o      = r_drop_cnt;
   assign last_drop_qpn_o = r_last_qpn;

   ids_beat_fifo #(
      .WIDTH (c_fifo_bits),
      .DEPTH (DEPTH_BEATS)
   ) u_fifo (
      .clk       (nclk),
      .rst       (nreset),
      .i_wr_en   (w_wr),
      .i_wr_data ({s_axis_rx_tdata, s_axis_rx_tkeep, s_axis_rx_tlast}),
      .i_rd_en   (w_rd),
      .o_rd_data (w_head),
      .o_count   (w_occ),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   always_ff @(posedge nclk) begin
      if (nreset) begin
         r_state    <= ST_IDLE;
         r_pass_cnt <= '0;
         r_drop_cnt <= '0;
         r_last_qpn <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_dec_accept) begin
                  if (w_dec.drop) begin
                     r_state    <= ST_DROP;
                     r_last_qpn <= w_dec.qpn;
                  end else begin
                     r_state <= ST_PASS;
                  end
               end
            end
            ST_PASS: begin
               if (w_rd && w_head_last) begin
                  r_pass_cnt <= r_pass_cnt + 32'd1;
                  r_state    <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (w_rd && w_head_last) begin
                  r_drop_cnt <= r_drop_cnt + 32'd1;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_intrusion_payload_gate.sv
`default_nettype none
// ============================================================================
// tb_intrusion_payload_gate : directed scenarios plus randomized traffic against a packet-level model
// Rev 1.0
// ============================================================================
module tb_intrusion_payload_gate;

   typedef struct packed {
      logic [511:0] d;
      logic [63:0]  k;
      logic         l;
   } beat_t;

   logic         clk = 1'b0;
   logic         nreset;
   logic [511:0] s_axis_rx_tdata;
   logic [63:0]  s_axis_rx_tkeep;
   logic         s_axis_rx_tlast;
   logic         s_axis_rx_tvalid;
   logic         s_axis_rx_tready;
   logic [24:0]  s_decision_data;
   logic         s_decision_valid;
   logic         s_decision_ready;
   logic [511:0] m_axis_tx_tdata;
   logic [63:0]  m_axis_tx_tkeep;
   logic         m_axis_tx_tlast;
   logic         m_axis_tx_tvalid;
   logic         m_axis_tx_tready;
   logic [31:0]  pass_cnt_o;
   logic [31:0]  drop_cnt_o;
   logic [23:0]  last_drop_qpn_o;

   always #5 clk = ~clk;

   intrusion_payload_gate #(
      .DEPTH_BEATS (128),
      .DATA_BITS   (512)
   ) dut (
      .nclk             (clk),
      .nreset           (nreset),
      .s_axis_rx_tdata  (s_axis_rx_tdata),
      .s_axis_rx_tkeep  (s_axis_rx_tkeep),
      .s_axis_rx_tlast  (s_axis_rx_tlast),
      .s_axis_rx_tvalid (s_axis_rx_tvalid),
      .s_axis_rx_tready (s_axis_rx_tready),
      .s_decision_data  (s_decision_data),
      .s_decision_valid (s_decision_valid),
      .s_decision_ready (s_decision_ready),
      .m_axis_tx_tdata  (m_axis_tx_tdata),
      .m_axis_tx_tkeep  (m_axis_tx_tkeep),
      .m_axis_tx_tlast  (m_axis_tx_tlast),
      .m_axis_tx_tvalid (m_axis_tx_tvalid),
      .m_axis_tx_tready (m_axis_tx_tready),
      .pass_cnt_o       (pass_cnt_o),
      .drop_cnt_o       (drop_cnt_o),
      .last_drop_qpn_o  (last_drop_qpn_o)
   );

   // Model: expected egress stream (beats of passed packets in order) and packet counters.
   beat_t       exp_q[$];
   logic [31:0] exp_pass;
   logic [31:0] exp_drop;
   logic [23:0] exp_qpn;
   int          n_chk  = 0;
   int          n_pass = 0;

   task automatic chk(input string nm, input logic [576:0] act, input logic [576:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h required %0h", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single compare process for the egress stream.
   always @(negedge clk) begin
      if (!nreset && m_axis_tx_tvalid && m_axis_tx_tready) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL spurious_beat: got tvalid=1 tdata[31:0]=%0h required no pending beat",
                     m_axis_tx_tdata[31:0]);
         end else begin
            chk("egress_beat", {m_axis_tx_tdata, m_axis_tx_tkeep, m_axis_tx_tlast},
                exp_q.pop_front());
         end
      end
   end

   function automatic beat_t rnd_beat(input logic last);
      beat_t b;
      for (int i = 0; i < 16; i++) b.d[i*32 +: 32] = $urandom;
      b.k = last ? {$urandom, $urandom} : '1;
      b.l = last;
      return b;
   endfunction

   task automatic send_beat(input beat_t b);
      int   n = 0;
      logic acc = 1'b0;
      s_axis_rx_tdata  = b.d;
      s_axis_rx_tkeep  = b.k;
      s_axis_rx_tlast  = b.l;
      s_axis_rx_tvalid = 1'b1;
      while (!acc && n < 5000) begin
         @(negedge clk);
         acc = s_axis_rx_tready;
         tick();
         n++;
      end
      if (!acc) begin
         n_chk++;
         $display("FAIL ingress_timeout: got tready=0 for %0d cycles required acceptance", n);
      end
      s_axis_rx_tvalid = 1'b0;
   endtask

   task automatic send_verdict(input logic [24:0] v);
      int   n = 0;
      logic acc = 1'b0;
      s_decision_data  = v;
      s_decision_valid = 1'b1;
      while (!acc && n < 5000) begin
         @(negedge clk);
         acc = s_decision_ready;
         tick();
         n++;
      end
      if (!acc) begin
         n_chk++;
         $display("FAIL verdict_timeout: got ready=0 for %0d cycles required acceptance", n);
      end
      s_decision_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         n_chk++;
         $display("FAIL drain_timeout: got %0d pending beats required 0", exp_q.size());
         exp_q.delete();
      end
      repeat (12) tick();
   endtask

   task automatic check_counters(input string tag);
      chk({tag, "_pass_cnt"}, pass_cnt_o, exp_pass);
      chk({tag, "_drop_cnt"}, drop_cnt_o, exp_drop);
      chk({tag, "_last_qpn"}, last_drop_qpn_o, exp_qpn);
   endtask

   task automatic run_random(input int npkt);
      beat_t       beats[$];
      logic [24:0] vq[$];
      logic        done = 1'b0;
      for (int p = 0; p < npkt; p++) begin
         int          len = $urandom_range(1, 8);
         logic        drop = 1'($urandom_range(0, 1));
         logic [23:0] qpn = 24'($urandom);
         for (int j = 0; j < len; j++) begin
            beat_t b = rnd_beat(j == len - 1);
            beats.push_back(b);
            if (!drop) exp_q.push_back(b);
         end
         vq.push_back({drop, qpn});
         if (drop) begin
            exp_drop = exp_drop + 32'd1;
            exp_qpn  = qpn;
         end else begin
            exp_pass = exp_pass + 32'd1;
         end
      end
      fork
         begin
            fork
               foreach (beats[i]) begin
                  repeat ($urandom_range(0, 2)) tick();
                  send_beat(beats[i]);
               end
               foreach (vq[i]) begin
                  repeat ($urandom_range(0, 6)) tick();
                  send_verdict(vq[i]);
               end
            join
            done = 1'b1;
         end
         begin
            for (int n = 0; n < 40000 && !done; n++) begin
               m_axis_tx_tready = ($urandom_range(0, 3) != 0);
               tick();
            end
         end
      join
      m_axis_tx_tready = 1'b1;
      drain();
      check_counters("random");
   endtask

   initial begin
      beat_t pkt[3];
      beat_t big[$];
      beat_t one;

      nreset           = 1'b1;
      s_axis_rx_tdata  = '0;
      s_axis_rx_tkeep  = '0;
      s_axis_rx_tlast  = 1'b0;
      s_axis_rx_tvalid = 1'b0;
      s_decision_data  = '0;
      s_decision_valid = 1'b0;
      m_axis_tx_tready = 1'b1;
      exp_pass = '0;
      exp_drop = '0;
      exp_qpn  = '0;

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      chk("rst_rx_ready", s_axis_rx_tready, 0);
      chk("rst_dec_ready", s_decision_ready, 0);
      chk("rst_tx_valid", m_axis_tx_tvalid, 0);
      check_counters("rst");
      tick();
      nreset = 1'b0;
      @(negedge clk);
      chk("post_rst_rx_ready", s_axis_rx_tready, 1);
      tick();

      // 3-beat pass
      pkt[0] = rnd_beat(1'b0);
      pkt[0].d[79:0] = 80'h1164004000002c040245;
      pkt[1] = rnd_beat(1'b0);
      pkt[2] = rnd_beat(1'b1);
      pkt[2].k = 64'h00000fffffffffff;
      foreach (pkt[i]) begin
         exp_q.push_back(pkt[i]);
         send_beat(pkt[i]);
      end
      send_verdict({1'b0, 24'h000011});
      exp_pass = exp_pass + 32'd1;
      drain();
      chk("t1_pass_cnt", pass_cnt_o, 32'd1);
      chk("t1_drop_cnt", drop_cnt_o, 32'd0);

      // Same packet dropped: buffered 3 beats drain in exactly 3 cycles
      foreach (pkt[i]) send_beat(pkt[i]);
      send_verdict({1'b1, 24'h000011});
      exp_drop = exp_drop + 32'd1;
      exp_qpn  = 24'h000011;
      repeat (2) tick();
      @(negedge clk);
      chk("t2_drop_not_early", drop_cnt_o, 32'd0);
      tick();
      @(negedge clk);
      chk("t2_drop_cnt", drop_cnt_o, 32'd1);
      chk("t2_last_qpn", last_drop_qpn_o, 24'h000011);
      chk("t2_fifo_empty_no_ready", s_decision_ready, 0);
      tick();

      // Back-to-back: A passed, B dropped
      for (int i = 0; i < 2; i++) begin
         one = rnd_beat(i == 1);
         exp_q.push_back(one);
         send_beat(one);
      end
      for (int i = 0; i < 3; i++) send_beat(rnd_beat(i == 2));
      send_verdict({1'b0, 24'h000022});
      send_verdict({1'b1, 24'h000033});
      exp_pass = exp_pass + 32'd1;
      exp_drop = exp_drop + 32'd1;
      exp_qpn  = 24'h000033;
      drain();
      chk("t3_pass_cnt", pass_cnt_o, 32'd2);
      chk("t3_drop_cnt", drop_cnt_o, 32'd2);
      chk("t3_last_qpn", last_drop_qpn_o, 24'h000033);

      // Early verdict waits for the first beat
      s_decision_data  = {1'b0, 24'h000044};
      s_decision_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_early_ready_low", s_decision_ready, 0);
         tick();
      end
      one = rnd_beat(1'b1);
      exp_q.push_back(one);
      send_beat(one);
      @(negedge clk);
      chk("t5_ready_after_write", s_decision_ready, 1);
      tick();
      s_decision_valid = 1'b0;
      exp_pass = exp_pass + 32'd1;
      drain();
      check_counters("t5");

      // Backpressure: 128-beat packet fills the FIFO
      m_axis_tx_tready = 1'b0;
      for (int i = 0; i < 128; i++) begin
         one = rnd_beat(i == 127);
         big.push_back(one);
         exp_q.push_back(one);
         send_beat(one);
      end
      @(negedge clk);
      chk("t4_full_stalls", s_axis_rx_tready, 0);
      tick();
      send_verdict({1'b0, 24'h000055});
      exp_pass = exp_pass + 32'd1;
      @(negedge clk);
      chk("t4_still_full", s_axis_rx_tready, 0);
      tick();
      m_axis_tx_tready = 1'b1;
      drain();
      check_counters("t4");

      // Reset in the middle of a passing packet
      m_axis_tx_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         pkt[i] = rnd_beat(i == 2);
         send_beat(pkt[i]);
      end
      exp_q.push_back(pkt[0]);
      send_verdict({1'b0, 24'h000066});
      m_axis_tx_tready = 1'b1;
      tick();
      nreset = 1'b1;
      tick();
      @(negedge clk);
      chk("t6_rst_tx_valid", m_axis_tx_tvalid, 0);
      chk("t6_rst_rx_ready", s_axis_rx_tready, 0);
      exp_pass = '0;
      exp_drop = '0;
      exp_qpn  = '0;
      check_counters("t6_rst");
      tick();
      nreset = 1'b0;
      @(negedge clk);
      chk("t6_rx_ready_back", s_axis_rx_tready, 1);
      chk("t6_fifo_empty", s_decision_ready, 0);
      tick();
      one = rnd_beat(1'b1);
      exp_q.push_back(one);
      send_beat(one);
      send_verdict({1'b0, 24'h000077});
      exp_pass = exp_pass + 32'd1;
      drain();
      chk("t6_pass_after_rst", pass_cnt_o, 32'd1);

      // Randomized traffic
      run_random(40);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
